// File: rtl/uart_mmio_pkg.sv
// ============================================================================
// Module   : uart_mmio_pkg
// Purpose  : Shared constants, FSM state type and read-sizing helper for the
//            memory-mapped UART transmitter.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package uart_mmio_pkg;

    localparam logic [1:0] REG_TXDATA  = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_BAUDDIV = 2'd2;
    localparam logic [1:0] REG_CTRL    = 2'd3;

    localparam logic [1:0] OPT_NONE = 2'b00;
    localparam logic [1:0] OPT_BYTE = 2'b01;
    localparam logic [1:0] OPT_HALF = 2'b10;
    localparam logic [1:0] OPT_WORD = 2'b11;

    localparam int STAT_BUSY  = 0;
    localparam int STAT_FULL  = 1;
    localparam int STAT_EMPTY = 2;
    localparam int STAT_OVF   = 3;

    localparam int CTRL_TX_EN   = 0;
    localparam int CTRL_IRQ_EN  = 1;
    localparam int CTRL_OVF_CLR = 2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } tx_state_t;

    // Narrow a register value to the requested access width, optionally sign-extending.
    function automatic logic [31:0] size_read(input logic [31:0] raw,
                                              input logic [1:0]  opt,
                                              input logic        sext);
        logic [31:0] res;
        unique case (opt)
            OPT_BYTE: res = {{24{sext & raw[7]}}, raw[7:0]};
            OPT_HALF: res = {{16{sext & raw[15]}}, raw[15:0]};
            OPT_WORD: res = raw;
            default:  res = 32'h0;
        endcase
        return res;
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_tx_mmio_sync_fifo8.sv
// ============================================================================
// Module   : sync_fifo8
// Purpose  : Byte-wide synchronous FIFO with show-ahead head output.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module sync_fifo8 #(
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [7:0]               din,
    input  logic                     pop,
    output logic [7:0]               dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     accept
);
    localparam int unsigned AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign full   = (count_q == FULL_CNT);
    assign empty  = (count_q == '0);
    assign count  = count_q;
    assign dout   = mem_q[rd_ptr_q];
    assign accept = do_push;

    // A push into a full FIFO still fits when the head leaves on the same edge.
    always_comb begin
        do_pop   = pop & ~empty;
        do_push  = push & (~full | do_pop);
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_tx_mmio.sv
// ============================================================================
// Module   : uart_tx_mmio
// Purpose  : Bus-responder UART transmitter (8N1) with TX FIFO, status,
//            baud divisor and control registers, and a level interrupt.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_tx_mmio
    import uart_mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h4000_0010,
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic [31:0] wdata,
    input  logic [1:0]  read_option,
    input  logic [1:0]  write_option,
    input  logic        extra_op,
    output logic [31:0] rdata,
    output logic        uart_txd,
    output logic        tx_irq
);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    logic          sel, wr_any, wr_word, push, pop;
    logic [1:0]    reg_idx;
    logic [7:0]    fifo_dout;
    logic          fifo_full, fifo_empty, fifo_accept;
    logic [CW-1:0] fifo_count;
    logic [15:0]   div_eff, reload;
    logic [31:0]   status, raw;
    logic          unused_bits;

    tx_state_t     state_q, state_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          txd_q, txd_d;
    logic [15:0]   baud_q, baud_d;
    logic          tx_en_q, tx_en_d;
    logic          irq_en_q, irq_en_d;
    logic          ovf_q, ovf_d;
    logic          irq_q, irq_d;

    assign sel         = (address[31:4] == BASE_ADDR[31:4]);
    assign reg_idx     = address[3:2];
    assign wr_any      = sel & (write_option != OPT_NONE);
    assign wr_word     = sel & (write_option == OPT_WORD);
    assign push        = wr_any & (reg_idx == REG_TXDATA);
    assign unused_bits = ^{address[1:0], wdata[31:16]};

    sync_fifo8 #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .push   (push),
        .din    (wdata[7:0]),
        .pop    (pop),
        .dout   (fifo_dout),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (fifo_count),
        .accept (fifo_accept)
    );

    assign div_eff = (baud_q == 16'd0) ? 16'd1 : baud_q;
    assign reload  = div_eff - 16'd1;

    always_comb begin
        status                 = 32'h0;
        status[STAT_BUSY]      = (state_q != S_IDLE);
        status[STAT_FULL]      = fifo_full;
        status[STAT_EMPTY]     = fifo_empty;
        status[STAT_OVF]       = ovf_q;
        status[15:8]           = 8'(fifo_count);
        unique case (reg_idx)
            REG_STATUS:  raw = status;
            REG_BAUDDIV: raw = {16'h0, baud_q};
            REG_CTRL:    raw = {30'h0, irq_en_q, tx_en_q};
            default:     raw = 32'h0;
        endcase
        rdata = sel ? size_read(raw, read_option, extra_op) : 32'h0;
    end

    // Serialiser: the divisor is re-read at every bit boundary via reload.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        txd_d   = txd_q;
        pop     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                txd_d = 1'b1;
                if (tx_en_q && !fifo_empty) begin
                    pop     = 1'b1;
                    shreg_d = fifo_dout;
                    cnt_d   = reload;
                    txd_d   = 1'b0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (cnt_q == 16'd0) begin
                    cnt_d   = reload;
                    bit_d   = 3'd0;
                    txd_d   = shreg_q[0];
                    state_d = S_DATA;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_DATA: begin
                if (cnt_q == 16'd0) begin
                    cnt_d = reload;
                    if (bit_q == 3'd7) begin
                        txd_d   = 1'b1;
                        state_d = S_STOP;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shreg_d = {1'b0, shreg_q[7:1]};
                        txd_d   = shreg_q[1];
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_STOP: begin
                if (cnt_q == 16'd0) begin
                    if (tx_en_q && !fifo_empty) begin
                        pop     = 1'b1;
                        shreg_d = fifo_dout;
                        cnt_d   = reload;
                        txd_d   = 1'b0;
                        state_d = S_START;
                    end else begin
                        txd_d   = 1'b1;
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        baud_d   = baud_q;
        tx_en_d  = tx_en_q;
        irq_en_d = irq_en_q;
        ovf_d    = ovf_q | (push & ~fifo_accept);
        if (wr_word && reg_idx == REG_BAUDDIV) begin
            baud_d = wdata[15:0];
        end
        if (wr_word && reg_idx == REG_CTRL) begin
            tx_en_d  = wdata[CTRL_TX_EN];
            irq_en_d = wdata[CTRL_IRQ_EN];
            if (wdata[CTRL_OVF_CLR]) begin
                ovf_d = 1'b0;
            end
        end
        irq_d = irq_en_q & fifo_empty & (state_q == S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= 16'd0;
            bit_q    <= 3'd0;
            shreg_q  <= 8'd0;
            txd_q    <= 1'b1;
            baud_q   <= DEFAULT_DIV;
            tx_en_q  <= 1'b1;
            irq_en_q <= 1'b0;
            ovf_q    <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            shreg_q  <= shreg_d;
            txd_q    <= txd_d;
            baud_q   <= baud_d;
            tx_en_q  <= tx_en_d;
            irq_en_q <= irq_en_d;
            ovf_q    <= ovf_d;
            irq_q    <= irq_d;
        end
    end

    assign uart_txd = txd_q;
    assign tx_irq   = irq_q;

endmodule

`default_nettype wire
